dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the CPU core's load/store port: it serves the `en_fetch_data` / `en_store_data` requests that the CPU drives with `alu_result` as the byte address and `Rdata2` as store data. It adds programmable wait states, a one-cycle `mem_ready` completion strobe and an error strobe for misaligned or out-of-range accesses. It replaces a zero-latency RAM so the pipeline's stall logic can be exercised against realistic memory latency.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `WAIT_CYCLES`, 2: extra busy cycles per access, 0–15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en_fetch_data` input 1: load request, level.
- `en_store_data` input 1: store request, level.
- `alu_result` input 32: byte address.
- `Rdata2` input 32: store data.
- `data_m` output 32: load data; holds the last successful load.
- `mem_ready` output 1: one-cycle completion strobe.
- `mem_err` output 1: one-cycle error strobe; only asserted together with `mem_ready`.
- `mem_busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** the enables are sampled only in this state.
  - Request valid when exactly one enable is high.
  - On acceptance, capture the address, data and op.
  - Both enables high: illegal. Go to RESP with error flagged. No access.
- **Error checks at acceptance:**
  - Misaligned: `alu_result[1:0] != 0`.
  - Out of range: word index `alu_result[31:2] >= DEPTH_WORDS`.
  - Either case: go to RESP with error flagged, no write, `data_m` unchanged.
- **Legal access:**
  - `WAIT_CYCLES == 0`: go straight to RESP.
  - Otherwise load the wait counter with `WAIT_CYCLES`, go to WAIT, decrement each cycle, and go to RESP on the cycle the counter reaches 1.
- **Commit:**
  - A store writes the array on the edge that enters RESP.
  - A load registers the array word into `data_m` on the same edge.
- **RESP:** lasts one cycle, then IDLE.
  - `mem_ready = 1`; `mem_err` = error flag.
  - An enable still high in the following IDLE cycle is a new request.
- **Outputs in IDLE/WAIT:** `mem_ready = 0`, `mem_err = 0`.
- **Ignored inputs:** enables that change during WAIT/RESP are ignored. The captured address and data are used.
- **Reset:**
  - `rst` drives state to IDLE and the counter to 0.
  - `data_m = 0`, `mem_ready = 0`, `mem_err = 0`, `mem_busy = 0`.
  - Array contents are not cleared.
  - Reset during WAIT discards the pending store; no write occurs.
  - Reset has priority over all other events on the same edge.

## Timing
- Request accepted at edge N.
- `mem_ready` is high in the cycle after edge N+1+`WAIT_CYCLES`:
  - `WAIT_CYCLES = 2`: accepted at edge 0, RESP during cycle 3.
  - `WAIT_CYCLES = 0`: RESP during cycle 1.
  - Error responses always take 1 cycle.
- `data_m` is valid from the RESP cycle and stable until the next successful load commits.
- Throughput: one access per `WAIT_CYCLES + 2` cycles. The mandatory IDLE cycle between accesses is intentional.
- Store then load to the same address back-to-back: the load returns the new data, because the write completes before the load's read.

## Structure
- Shared package `dmem_pkg`:
  - state enum `{IDLE, WAIT, RESP}`;
  - op enum `{OP_LOAD, OP_STORE}`;
  - `WORD_BYTES = 4`.
- Sub-module `dmem_array`: `DEPTH_WORDS` x 32, single port, synchronous write, combinational read. Instantiated once.
- The FSM, wait counter, capture registers and error logic live in `dmem_responder`.

## Test plan
- Store `0xDEADBEEF` to `0x10`, then load `0x10`:
  - each `mem_ready` arrives 3 cycles after acceptance;
  - `data_m = 0xDEADBEEF`, `mem_err = 0`.
- Load `0x12` (misaligned):
  - `mem_ready` and `mem_err` both high in the cycle after acceptance;
  - `data_m` unchanged.
- Store to `0x400` with `DEPTH_WORDS = 256`:
  - `mem_err = 1`;
  - a following load of `0x0` returns the prior contents (no wrap-around write).
- Both enables high at `0x20`: `mem_err = 1`, no write; a later load of `0x20` returns the old value.
- Store `0x55` to `0x8`, assert `rst` during WAIT:
  - outputs go to 0 on the next edge;
  - a later load of `0x8` returns the pre-store value.
- `WAIT_CYCLES = 0`, enable held high for 6 cycles: exactly 3 `mem_ready` pulses, in cycles 1, 3 and 5.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   op_t       : captured operation kind (load / store)
//   WORD_BYTES : bytes per memory word
//   addr_error : flags a misaligned or out-of-range byte address
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

    localparam int unsigned WORD_BYTES = 32'd4;

    // An access is rejected when the byte address is not word aligned or when
    // the word index falls beyond the end of the array (no wrap-around).
    function automatic logic addr_error(input logic [31:0] addr,
                                        input int unsigned depth_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[31:2]} >= depth_words);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store port between the CPU core (master) and the data-memory
// responder (slave).
//   en_fetch_data : load request (level)
//   en_store_data : store request (level)
//   alu_result    : byte address
//   Rdata2        : store data
//   data_m        : load data, holds the last successful load
//   mem_ready     : one-cycle completion strobe
//   mem_err       : one-cycle error strobe, only together with mem_ready
//   mem_busy      : responder is not idle
// -----------------------------------------------------------------------------
interface dmem_responder_if;

    logic        en_fetch_data;
    logic        en_store_data;
    logic [31:0] alu_result;
    logic [31:0] Rdata2;
    logic [31:0] data_m;
    logic        mem_ready;
    logic        mem_err;
    logic        mem_busy;

    modport master (
        output en_fetch_data,
        output en_store_data,
        output alu_result,
        output Rdata2,
        input  data_m,
        input  mem_ready,
        input  mem_err,
        input  mem_busy
    );

    modport slave (
        input  en_fetch_data,
        input  en_store_data,
        input  alu_result,
        input  Rdata2,
        output data_m,
        output mem_ready,
        output mem_err,
        output mem_busy
    );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH_WORDS x 32 single-port storage: synchronous write, combinational read.
// Contents are never reset.
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : read data at addr
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 32'd256,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Word write on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the CPU load/store port. Accepts one request in
// IDLE, optionally waits WAIT_CYCLES busy cycles, commits the access on the
// edge that enters RESP and pulses mem_ready (with mem_err on a rejected
// request) for exactly one cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : load/store port (slave side), see dmem_responder_if
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32'd256,
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [AW-1:0]   widx_r, widx_s;
    logic [31:0]     wdata_r, wdata_s;
    op_t             op_r, op_s;
    logic            err_r, err_s;

    logic [31:0]     data_r;
    logic            ready_r;
    logic            err_out_r;
    logic            busy_r;

    logic            commit_s;
    logic            we_s;
    logic            load_s;
    logic [31:0]     rdata_s;

    // Next-state, wait counter and request capture.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        widx_s  = widx_r;
        wdata_s = wdata_r;
        op_s    = op_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (bus.en_fetch_data && bus.en_store_data) begin
                    // Conflicting request: answered with an error, no access.
                    widx_s  = bus.alu_result[AW+1:2];
                    wdata_s = bus.Rdata2;
                    op_s    = OP_LOAD;
                    err_s   = 1'b1;
                    state_s = RESP;
                end else if (bus.en_fetch_data || bus.en_store_data) begin
                    widx_s  = bus.alu_result[AW+1:2];
                    wdata_s = bus.Rdata2;
                    op_s    = bus.en_store_data ? OP_STORE : OP_LOAD;
                    err_s   = addr_error(bus.alu_result, DEPTH_WORDS);
                    if (err_s) begin
                        state_s = RESP;
                    end else if (WAIT_CYCLES == 32'd0) begin
                        state_s = RESP;
                    end else begin
                        cnt_s   = 4'(WAIT_CYCLES);
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // Leave on the cycle the counter shows 1, so a legal access
                // spends WAIT_CYCLES cycles here.
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = RESP;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Commit strobes: the access happens on the edge that enters RESP.
    // Reset on the same edge cancels the access.
    always_comb begin
        commit_s = 1'b0;
        we_s     = 1'b0;
        load_s   = 1'b0;
        if ((state_s == RESP) && (state_r != RESP) && !err_s && !rst) begin
            commit_s = 1'b1;
            we_s     = (op_s == OP_STORE);
            load_s   = (op_s == OP_LOAD);
        end else begin
            commit_s = 1'b0;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (widx_s),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // FSM state, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            widx_r    <= '0;
            wdata_r   <= 32'd0;
            op_r      <= OP_LOAD;
            err_r     <= 1'b0;
            data_r    <= 32'd0;
            ready_r   <= 1'b0;
            err_out_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            widx_r    <= widx_s;
            wdata_r   <= wdata_s;
            op_r      <= op_s;
            err_r     <= err_s;
            ready_r   <= (state_s == RESP);
            err_out_r <= (state_s == RESP) && err_s;
            busy_r    <= (state_s != IDLE);
            if (load_s && commit_s) begin
                data_r <= rdata_s;
            end
        end
    end

    assign bus.data_m    = data_r;
    assign bus.mem_ready = ready_r;
    assign bus.mem_err   = err_out_r;
    assign bus.mem_busy  = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with WAIT_CYCLES = 2 and a
// second with WAIT_CYCLES = 0 for the back-to-back throughput case.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance; inputs are scrambled after
    // acceptance so only the captured values can produce the right answer.
    task automatic access(input string tag, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_data);
        int   lat      = 0;
        logic err_seen = 1'b0;
        @(negedge clk);
        bus.en_fetch_data = ld;
        bus.en_store_data = st;
        bus.alu_result    = addr;
        bus.Rdata2        = data;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.en_fetch_data = 1'b0;
                bus.en_store_data = 1'b0;
                bus.alu_result    = 32'hFFFF_FFFC;
                bus.Rdata2        = 32'h0BAD_0BAD;
            end
            if (bus.mem_ready) begin
                lat      = n;
                err_seen = bus.mem_err;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
        check({tag, " data_m"}, bus.data_m, exp_data);
    endtask

    logic [5:0] pat;

    initial begin
        rst = 1'b1;
        bus.en_fetch_data  = 1'b0;
        bus.en_store_data  = 1'b0;
        bus.alu_result     = 32'd0;
        bus.Rdata2         = 32'd0;
        bus0.en_fetch_data = 1'b0;
        bus0.en_store_data = 1'b0;
        bus0.alu_result    = 32'd0;
        bus0.Rdata2        = 32'd0;
        pat = 6'd0;
        repeat (2) @(negedge clk);
        check("reset data_m", bus.data_m, 32'd0);
        check("reset ready", {31'd0, bus.mem_ready}, 32'd0);
        check("reset err", {31'd0, bus.mem_err}, 32'd0);
        check("reset busy", {31'd0, bus.mem_busy}, 32'd0);
        rst = 1'b0;

        // Known background contents.
        access("pre0", 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 3, 1'b0, 32'd0);
        access("pre20", 1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222, 3, 1'b0, 32'd0);
        access("pre8", 1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 3, 1'b0, 32'd0);

        // Store then load back-to-back.
        access("st10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'd0);
        access("ld10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 3, 1'b0, 32'hDEAD_BEEF);

        // Misaligned load: fast error, data_m unchanged.
        access("ld12", 1'b1, 1'b0, 32'h0000_0012, 32'd0, 1, 1'b1, 32'hDEAD_BEEF);

        // Out-of-range store must not wrap onto word 0.
        access("st400", 1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1, 1'b1, 32'hDEAD_BEEF);
        access("ld0", 1'b1, 1'b0, 32'h0000_0000, 32'd0, 3, 1'b0, 32'h1111_1111);

        // Both enables: error, no write.
        access("both20", 1'b1, 1'b1, 32'h0000_0020, 32'h9999_9999, 1, 1'b1, 32'h1111_1111);
        access("ld20", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 3, 1'b0, 32'h2222_2222);

        // Last legal word.
        access("st3fc", 1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 3, 1'b0, 32'h2222_2222);
        access("ld3fc", 1'b1, 1'b0, 32'h0000_03FC, 32'd0, 3, 1'b0, 32'hA5A5_A5A5);

        // Reset during WAIT discards a pending store.
        @(negedge clk);
        bus.en_store_data = 1'b1;
        bus.alu_result    = 32'h0000_0008;
        bus.Rdata2        = 32'h0000_0055;
        @(negedge clk);
        check("wait busy", {31'd0, bus.mem_busy}, 32'd1);
        check("wait ready", {31'd0, bus.mem_ready}, 32'd0);
        bus.en_store_data = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst data_m", bus.data_m, 32'd0);
        check("rst busy", {31'd0, bus.mem_busy}, 32'd0);
        check("rst ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst err", {31'd0, bus.mem_err}, 32'd0);
        rst = 1'b0;
        access("ld8", 1'b1, 1'b0, 32'h0000_0008, 32'd0, 3, 1'b0, 32'h3333_3333);

        // Zero-wait instance: single-cycle store.
        @(negedge clk);
        bus0.en_store_data = 1'b1;
        bus0.alu_result    = 32'h0000_0004;
        bus0.Rdata2        = 32'h1234_5678;
        @(negedge clk);
        bus0.en_store_data = 1'b0;
        check("w0 st ready", {31'd0, bus0.mem_ready}, 32'd1);
        check("w0 st err", {31'd0, bus0.mem_err}, 32'd0);

        // Load held for 6 cycles: pulses in cycles 1, 3 and 5.
        @(negedge clk);
        bus0.en_fetch_data = 1'b1;
        bus0.alu_result    = 32'h0000_0004;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            pat[n-1] = bus0.mem_ready;
        end
        bus0.en_fetch_data = 1'b0;
        check("w0 pulse pattern", {26'd0, pat}, 32'h0000_0015);
        check("w0 data_m", bus0.data_m, 32'h1234_5678);
        @(negedge clk);
        check("w0 idle busy", {31'd0, bus0.mem_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
